// File: rtl/cpu_defs.sv
// Shared fetch/decode definitions: address width, fetch FSM states, decoder opcodes.
package cpu_defs;
  localparam int ADDR_W     = 7;
  localparam int WORD_BYTES = 4;

  typedef enum logic [1:0] {
    FS_BOOT = 2'd0,
    FS_RUN  = 2'd1,
    FS_HALT = 2'd2
  } fetch_state_e;

  localparam logic [5:0] OP_J   = 6'h02;
  localparam logic [5:0] OP_BEQ = 6'h04;
endpackage

// File: rtl/fetch_pc_unit_next_pc_calc.sv
// Next-PC selection for fetch: jump > branch > sequential; flags redirects that target the current PC.
// Latency: purely combinational; backpressure: none (stall is applied by the caller).
module next_pc_calc
  import cpu_defs::*;
#(
  parameter int ADDR_W = cpu_defs::ADDR_W
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] pc_plus4,
  input  logic              branch_taken,
  input  logic [15:0]       branch_offset,
  input  logic              jump,
  input  logic [25:0]       jump_target,
  output logic [ADDR_W-1:0] next_pc,
  output logic              self_loop
);
  logic [ADDR_W-1:0] jump_addr;
  logic [ADDR_W-1:0] branch_addr;
  logic [ADDR_W-1:0] redirect_addr;

  // Sign bits above ADDR_W cannot affect a mod-2^ADDR_W sum, so only the low offset bits are kept.
  assign jump_addr     = {jump_target[ADDR_W-3:0], 2'b00};
  assign branch_addr   = pc_plus4 + {branch_offset[ADDR_W-3:0], 2'b00};
  assign redirect_addr = jump ? jump_addr : branch_addr;

  always_comb begin
    next_pc   = pc_plus4;
    self_loop = 1'b0;
    if (jump || branch_taken) begin
      next_pc   = redirect_addr;
      self_loop = (redirect_addr == pc);
    end
  end
endmodule

// File: rtl/fetch_pc_unit.sv
// Program counter and fetch sequencer feeding instruction_memory, with boot delay, halt detect, retire count.
// Latency: redirects visible on read_addr the cycle after sampling; backpressure: stall freezes PC and count.
module fetch_pc_unit
  import cpu_defs::*;
#(
  parameter int                ADDR_W   = cpu_defs::ADDR_W,
  parameter int                CNT_W    = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [15:0]       branch_offset,
  input  logic              jump,
  input  logic [25:0]       jump_target,
  output logic [ADDR_W-1:0] read_addr,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic              fetch_valid,
  output logic              halted,
  output logic [CNT_W-1:0]  retired_count
);
  localparam logic [ADDR_W-1:0] LAST_PC = {{(ADDR_W-2){1'b1}}, 2'b00};

  fetch_state_e      state, state_d;
  logic [ADDR_W-1:0] pc_d;
  logic [CNT_W-1:0]  cnt_d;
  logic [ADDR_W-1:0] next_pc;
  logic              self_loop;
  logic              seq_wrap;

  assign pc_plus4    = read_addr + ADDR_W'(WORD_BYTES);
  assign fetch_valid = (state == FS_RUN);
  assign halted      = (state == FS_HALT);
  assign seq_wrap    = !jump && !branch_taken && (read_addr == LAST_PC);

  next_pc_calc #(.ADDR_W(ADDR_W)) u_next_pc (
    .pc            (read_addr),
    .pc_plus4      (pc_plus4),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .jump          (jump),
    .jump_target   (jump_target),
    .next_pc       (next_pc),
    .self_loop     (self_loop)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= FS_BOOT;
      read_addr     <= RESET_PC;
      retired_count <= '0;
    end else begin
      state         <= state_d;
      read_addr     <= pc_d;
      retired_count <= cnt_d;
    end
  end

  always_comb begin
    state_d = state;
    pc_d    = read_addr;
    cnt_d   = retired_count;
    case (state)
      FS_BOOT: state_d = FS_RUN;
      FS_RUN: begin
        if (!stall) begin
          cnt_d = (retired_count == '1) ? retired_count : retired_count + CNT_W'(1);
          // The halting instruction retires, but the PC stays on it.
          if (self_loop || seq_wrap) begin
            state_d = FS_HALT;
          end else begin
            pc_d = next_pc;
          end
        end
      end
      FS_HALT: state_d = FS_HALT;
      default: state_d = FS_BOOT;
    endcase
  end
endmodule
